// File: rtl/oc8051_page_guard.sv
// XRAM page protection unit: per-page read/write bitmaps, access checking,
// and a small violation log with interrupt, configured through an XDATA window.
module oc8051_page_guard #(
  parameter int          PAGE_SHIFT = 8,
  parameter logic [15:0] CFG_BASE   = 16'hFF80,
  parameter int          LOG_DEPTH  = 4,
  parameter int          SRC_W      = 3,
  parameter int          PC_LAG     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      pc,
  input  logic [SRC_W-1:0] acc_src,
  input  logic [15:0]      xram_addr,
  input  logic [7:0]       xram_data_in,
  input  logic             xram_stb,
  input  logic             xram_wr,
  input  logic             priv_lvl,
  input  logic             cfg_stb,
  input  logic             cfg_wr,
  output logic             cfg_ack,
  output logic             cfg_addr_range,
  output logic [7:0]       cfg_data_out,
  output logic             wr_en,
  output logic             rd_en,
  output logic             violation,
  output logic             irq
);

  localparam int NPAGES = 1 << (16 - PAGE_SHIFT);
  localparam int NB     = NPAGES / 8;
  localparam int PW     = 16 - PAGE_SHIFT;
  localparam int BW     = PW - 3;
  localparam int AW     = $clog2(LOG_DEPTH);
  localparam logic [15:0] NB16  = 16'(NB);
  localparam logic [15:0] RB16  = 16'(2 * NB);
  localparam logic [15:0] WIN16 = 16'(2 * NB + 8);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(LOG_DEPTH);

  logic [7:0]       wr_map_q [NB];
  logic [7:0]       rd_map_q [NB];
  logic             enf_q, enf_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drops_q, drops_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             irq_q, irq_d;
  logic             prev_viol_q;
  logic [15:0]      prev_addr_q;
  logic             prev_wr_q;
  logic             log_wr_q   [LOG_DEPTH];
  logic [SRC_W-1:0] log_src_q  [LOG_DEPTH];
  logic [15:0]      log_addr_q [LOG_DEPTH];
  logic [15:0]      log_pc_q   [LOG_DEPTH];

  logic [PW-1:0] page;
  logic          wr_bit, rd_bit;
  logic [15:0]   off;
  logic [2:0]    reg_sel;
  logic [BW-1:0] map_idx;
  logic          sel_wr_map, sel_rd_map, sel_reg;
  logic          cfg_we, ctrl_we, clr, pop, push, do_write, drop, empty, full;
  logic [15:0]   pc_lag;

  // Permission lookup for the page under the current address
  assign page      = xram_addr[15:PAGE_SHIFT];
  assign wr_bit    = wr_map_q[page[PW-1:3]][page[2:0]];
  assign rd_bit    = rd_map_q[page[PW-1:3]][page[2:0]];
  assign wr_en     = wr_bit || !enf_q;
  assign rd_en     = rd_bit || !enf_q;
  assign violation = xram_stb && enf_q && (xram_wr ? !wr_bit : !rd_bit);

  assign off            = xram_addr - CFG_BASE;
  assign cfg_addr_range = (xram_addr >= CFG_BASE) && (off < WIN16);
  assign cfg_ack        = cfg_stb && cfg_addr_range;
  assign reg_sel        = 3'(off - RB16);
  assign map_idx        = off[BW-1:0];
  assign sel_wr_map     = cfg_addr_range && (off < NB16);
  assign sel_rd_map     = cfg_addr_range && (off >= NB16) && (off < RB16);
  assign sel_reg        = cfg_addr_range && (off >= RB16);

  assign cfg_we   = cfg_ack && cfg_wr && priv_lvl;
  assign ctrl_we  = cfg_we && sel_reg && (reg_sel == 3'd2);
  assign clr      = cfg_we && sel_reg && (reg_sel == 3'd0) && xram_data_in[7];
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = cfg_we && sel_reg && (reg_sel == 3'd3) && !empty;
  // A strobe held on the same faulting access is logged only once
  assign push     = violation &&
                    !(prev_viol_q && (xram_addr == prev_addr_q) && (xram_wr == prev_wr_q));
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign irq      = irq_q;

  generate
    if (PC_LAG == 0) begin : g_no_lag
      assign pc_lag = pc;
    end else begin : g_lag
      logic [15:0] pc_dly_q [PC_LAG];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PC_LAG; i++) pc_dly_q[i] <= 16'h0000;
        end else begin
          pc_dly_q[0] <= pc;
          for (int i = 1; i < PC_LAG; i++) pc_dly_q[i] <= pc_dly_q[i-1];
        end
      end
      assign pc_lag = pc_dly_q[PC_LAG-1];
    end
  endgenerate

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    drops_d  = drops_q;
    enf_d    = enf_q;
    irq_en_d = irq_en_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_write && !pop)      count_d = count_q + 1'b1;
    else if (!do_write && pop) count_d = count_q - 1'b1;
    if (clr) begin
      ovf_d   = 1'b0;
      drops_d = 8'h00;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_d != 8'hFF) drops_d = drops_d + 8'h01;
    end
    if (ctrl_we) begin
      enf_d    = xram_data_in[0];
      irq_en_d = xram_data_in[1];
    end
    // Interrupt tracks the post-edge log state so it moves with push/pop
    irq_d = irq_en_d && ((count_d != '0) || ovf_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        wr_map_q[i] <= 8'hFF;
        rd_map_q[i] <= 8'hFF;
      end
      for (int i = 0; i < LOG_DEPTH; i++) begin
        log_wr_q[i]   <= 1'b0;
        log_src_q[i]  <= '0;
        log_addr_q[i] <= 16'h0000;
        log_pc_q[i]   <= 16'h0000;
      end
      enf_q       <= 1'b1;
      irq_en_q    <= 1'b1;
      ovf_q       <= 1'b0;
      drops_q     <= 8'h00;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      irq_q       <= 1'b0;
      prev_viol_q <= 1'b0;
      prev_addr_q <= 16'h0000;
      prev_wr_q   <= 1'b0;
    end else begin
      if (cfg_we && sel_wr_map) wr_map_q[map_idx] <= xram_data_in;
      if (cfg_we && sel_rd_map) rd_map_q[map_idx] <= xram_data_in;
      if (do_write) begin
        log_wr_q[wr_ptr_q]   <= xram_wr;
        log_src_q[wr_ptr_q]  <= acc_src;
        log_addr_q[wr_ptr_q] <= xram_addr;
        log_pc_q[wr_ptr_q]   <= pc_lag;
      end
      enf_q       <= enf_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      drops_q     <= drops_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      irq_q       <= irq_d;
      prev_viol_q <= violation;
      prev_addr_q <= xram_addr;
      prev_wr_q   <= xram_wr;
    end
  end

  always_comb begin
    cfg_data_out = 8'h00;
    if (sel_wr_map) begin
      cfg_data_out = wr_map_q[map_idx];
    end else if (sel_rd_map) begin
      cfg_data_out = rd_map_q[map_idx];
    end else if (sel_reg) begin
      case (reg_sel)
        3'd0: cfg_data_out = {ovf_q, empty, 6'(count_q)};
        3'd1: cfg_data_out = drops_q;
        3'd2: cfg_data_out = {6'b000000, irq_en_q, enf_q};
        3'd3: cfg_data_out = empty ? 8'h00 : {log_wr_q[rd_ptr_q], 2'b00, 5'(log_src_q[rd_ptr_q])};
        3'd4: cfg_data_out = empty ? 8'h00 : log_addr_q[rd_ptr_q][15:8];
        3'd5: cfg_data_out = empty ? 8'h00 : log_addr_q[rd_ptr_q][7:0];
        3'd6: cfg_data_out = empty ? 8'h00 : log_pc_q[rd_ptr_q][15:8];
        default: cfg_data_out = empty ? 8'h00 : log_pc_q[rd_ptr_q][7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_oc8051_page_guard.sv
// Directed bench for oc8051_page_guard with default parameters.
module tb_oc8051_page_guard;

  localparam logic [15:0] BASE    = 16'hFF80;
  localparam logic [15:0] A_WR0   = BASE;
  localparam logic [15:0] A_WR31  = BASE + 16'd31;
  localparam logic [15:0] A_RD0   = BASE + 16'd32;
  localparam logic [15:0] A_ST    = BASE + 16'd64;
  localparam logic [15:0] A_DROPS = BASE + 16'd65;
  localparam logic [15:0] A_CTRL  = BASE + 16'd66;
  localparam logic [15:0] A_TINFO = BASE + 16'd67;
  localparam logic [15:0] A_TAH   = BASE + 16'd68;
  localparam logic [15:0] A_TAL   = BASE + 16'd69;
  localparam logic [15:0] A_TPH   = BASE + 16'd70;
  localparam logic [15:0] A_TPL   = BASE + 16'd71;
  localparam logic [15:0] PC_INC  = 16'h0103;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [2:0]  acc_src;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_in;
  logic        xram_stb, xram_wr, priv_lvl, cfg_stb, cfg_wr;
  logic        cfg_ack, cfg_addr_range, wr_en, rd_en, violation, irq;
  logic [7:0]  cfg_data_out;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_q[$];

  oc8051_page_guard dut (
    .clk(clk), .rst(rst), .pc(pc), .acc_src(acc_src), .xram_addr(xram_addr),
    .xram_data_in(xram_data_in), .xram_stb(xram_stb), .xram_wr(xram_wr),
    .priv_lvl(priv_lvl), .cfg_stb(cfg_stb), .cfg_wr(cfg_wr), .cfg_ack(cfg_ack),
    .cfg_addr_range(cfg_addr_range), .cfg_data_out(cfg_data_out),
    .wr_en(wr_en), .rd_en(rd_en), .violation(violation), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pc = pc + PC_INC;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acc_src = '0; xram_addr = '0; xram_data_in = '0;
    xram_stb = 1'b0; xram_wr = 1'b0; priv_lvl = 1'b0; cfg_stb = 1'b0; cfg_wr = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic cfg_write(input logic [15:0] a, input logic [7:0] d, input logic pr);
    xram_addr = a; xram_data_in = d; priv_lvl = pr;
    cfg_stb = 1'b1; cfg_wr = 1'b1;
    tick();
    cfg_stb = 1'b0; cfg_wr = 1'b0; priv_lvl = 1'b0;
  endtask

  task automatic cfg_read(input logic [15:0] a, output logic [7:0] d);
    xram_addr = a; cfg_stb = 1'b1; cfg_wr = 1'b0;
    #1;
    d = cfg_data_out;
    cfg_stb = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cfg_read(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  initial begin
    logic [15:0] pc_at;
    logic [15:0] e;
    pc = 16'h1000;

    // Reset state
    do_reset();
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_viol", {15'd0, violation}, 16'd0);
    check_reg("rst_wr0", A_WR0, 8'hFF);
    check_reg("rst_rd0", A_RD0, 8'hFF);
    check_reg("rst_ctrl", A_CTRL, 8'h03);
    check_reg("rst_status", A_ST, 8'h40);
    xram_addr = 16'h1234; xram_wr = 1'b1; xram_stb = 1'b1; #1;
    check("rst_wr_en", {15'd0, wr_en}, 16'd1);
    check("rst_noviol", {15'd0, violation}, 16'd0);
    xram_stb = 1'b0;
    // Window boundaries
    xram_addr = BASE + 16'd71; cfg_stb = 1'b1; #1;
    check("win_last_ack", {15'd0, cfg_ack}, 16'd1);
    xram_addr = BASE + 16'd72; #1;
    check("win_past_range", {15'd0, cfg_addr_range}, 16'd0);
    check("win_past_ack", {15'd0, cfg_ack}, 16'd0);
    xram_addr = BASE - 16'd1; #1;
    check("win_below_range", {15'd0, cfg_addr_range}, 16'd0);
    cfg_stb = 1'b0;

    // Privileged bitmap write, then a faulting write
    cfg_write(A_WR0, 8'hFE, 1'b1);
    check_reg("wr0_fe", A_WR0, 8'hFE);
    xram_addr = 16'h0010; xram_wr = 1'b1; acc_src = 3'd2; xram_stb = 1'b1; #1;
    check("viol_set", {15'd0, violation}, 16'd1);
    check("viol_wr_en", {15'd0, wr_en}, 16'd0);
    check("viol_rd_en", {15'd0, rd_en}, 16'd1);
    pc_at = pc;
    tick();
    xram_stb = 1'b0; acc_src = '0;
    e = pc_at - 16'(4 * PC_INC);
    check("viol_irq", {15'd0, irq}, 16'd1);
    check_reg("viol_status", A_ST, 8'h01);
    check_reg("viol_tah", A_TAH, 8'h00);
    check_reg("viol_tal", A_TAL, 8'h10);
    check_reg("viol_tinfo", A_TINFO, 8'h82);
    check_reg("viol_tph", A_TPH, e[15:8]);
    check_reg("viol_tpl", A_TPL, e[7:0]);
    xram_addr = 16'h0010; xram_wr = 1'b0; xram_stb = 1'b1; #1;
    check("read_ok", {15'd0, violation}, 16'd0);
    xram_stb = 1'b0;
    // Enforcement off, then interrupt enable off
    cfg_write(A_CTRL, 8'h02, 1'b1);
    xram_addr = 16'h0010; xram_wr = 1'b1; xram_stb = 1'b1; #1;
    check("enf_off_wr_en", {15'd0, wr_en}, 16'd1);
    check("enf_off_viol", {15'd0, violation}, 16'd0);
    xram_stb = 1'b0;
    cfg_write(A_CTRL, 8'h00, 1'b1);
    check("irqen_off", {15'd0, irq}, 16'd0);

    // Unprivileged write is acked but ignored
    do_reset();
    xram_addr = A_WR0; xram_data_in = 8'hFE; priv_lvl = 1'b0;
    cfg_stb = 1'b1; cfg_wr = 1'b1; #1;
    check("unpriv_ack", {15'd0, cfg_ack}, 16'd1);
    tick();
    cfg_stb = 1'b0; cfg_wr = 1'b0;
    check_reg("unpriv_wr0", A_WR0, 8'hFF);
    xram_addr = 16'h0010; xram_wr = 1'b1; xram_stb = 1'b1; #1;
    check("unpriv_noviol", {15'd0, violation}, 16'd0);
    xram_stb = 1'b0;

    // Held strobe logs once; address change mid-hold logs again
    do_reset();
    cfg_write(A_WR0, 8'hFE, 1'b1);
    xram_addr = 16'h0010; xram_wr = 1'b1; xram_stb = 1'b1;
    repeat (5) tick();
    xram_addr = 16'h0011;
    tick();
    xram_stb = 1'b0;
    check_reg("hold_status", A_ST, 8'h02);
    check_reg("hold_tal0", A_TAL, 8'h10);
    cfg_write(A_TINFO, 8'h00, 1'b1);
    check_reg("hold_tal1", A_TAL, 8'h11);
    check_reg("hold_status2", A_ST, 8'h01);

    // Overflow: 6 violations into a 4-deep log
    do_reset();
    cfg_write(A_WR0, 8'hFE, 1'b1);
    xram_wr = 1'b1; xram_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xram_addr = 16'h0020 + 16'(i);
      if (i < 4) exp_q.push_back(xram_addr);
      tick();
    end
    xram_stb = 1'b0;
    check_reg("ovf_status", A_ST, 8'h84);
    check_reg("ovf_drops", A_DROPS, 8'h02);
    check("ovf_irq", {15'd0, irq}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check_reg("pop_tal", A_TAL, e[7:0]);
      cfg_write(A_TINFO, 8'h00, 1'b1);
    end
    check_reg("popped_status", A_ST, 8'hC0);
    check("popped_irq", {15'd0, irq}, 16'd1);
    cfg_write(A_TINFO, 8'h00, 1'b1);
    check_reg("pop_empty_status", A_ST, 8'hC0);
    check_reg("empty_tinfo", A_TINFO, 8'h00);
    cfg_write(A_ST, 8'h80, 1'b1);
    check("clr_irq", {15'd0, irq}, 16'd0);
    check_reg("clr_status", A_ST, 8'h40);
    check_reg("clr_drops", A_DROPS, 8'h00);

    // Full log: violation and pop in the same cycle, then async reset
    do_reset();
    cfg_write(A_WR0, 8'hFE, 1'b1);
    cfg_write(A_WR31, 8'h7F, 1'b1);
    check_reg("wr31", A_WR31, 8'h7F);
    xram_wr = 1'b1; xram_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xram_addr = 16'h0030 + 16'(i);
      tick();
    end
    xram_stb = 1'b0;
    check_reg("full_status", A_ST, 8'h04);
    xram_addr = A_TINFO; xram_data_in = 8'h00; xram_wr = 1'b1; xram_stb = 1'b1;
    priv_lvl = 1'b1; cfg_stb = 1'b1; cfg_wr = 1'b1; #1;
    check("both_viol", {15'd0, violation}, 16'd1);
    tick();
    xram_stb = 1'b0; cfg_stb = 1'b0; cfg_wr = 1'b0; priv_lvl = 1'b0;
    check_reg("both_status", A_ST, 8'h04);
    check_reg("both_drops", A_DROPS, 8'h00);
    check_reg("both_tal", A_TAL, 8'h31);
    check("pre_rst_irq", {15'd0, irq}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_irq", {15'd0, irq}, 16'd0);
    check_reg("async_rst_status", A_ST, 8'h40);
    check_reg("async_rst_wr0", A_WR0, 8'hFF);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
